uart_rx_fifo: RTL and testbench

- Parametrised UART receiver for the peripheral bus: oversampled start-bit detection, configurable data width and parity, and an RX FIFO with error and overflow reporting.
- Replaces the single-byte receive register in the peripheral block. The bus-side register decode reads `rdata` and pops via `rd`.
- `irq` feeds the peripheral interrupt output.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_rx_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the UART receive path: parity modes, FSM encoding,
// baud-divider arithmetic and parameter legality checks.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    // Clocks per oversample tick, rounded to nearest and never below one.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        longint den;
        longint q;
        den = longint'(baud) * longint'(os);
        q   = (longint'(clk_freq) + den / 2) / den;
        return (q < 1) ? 1 : int'(q);
    endfunction

    function automatic bit data_bits_ok(input int n);
        return (n >= 5) && (n <= 9);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
// First-word-fall-through synchronous FIFO. When empty, rdata keeps showing
// the last entry popped so the bus never sees stale memory contents.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? hold_q : mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        hold_d   = hold_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            hold_d   = mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// Oversampling UART receiver feeding an RX FIFO, with sticky frame/parity/
// overflow flags and an interrupt that is pending while data or errors exist.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    input  logic                          rd,
    output logic [DATA_BITS-1:0]          rdata,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    input  logic                          clr_err,
    output logic                          irq
);

    localparam int DIV  = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW   = $clog2(DIV) + 1;
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   TICK_LAST = TW'(DIV - 1);
    localparam logic [OS_W-1:0] OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0]      BIT_LAST  = 4'(DATA_BITS - 1);

    if (!data_bits_ok(DATA_BITS) || (OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0) ||
        (PARITY > PAR_EVEN) || (FIFO_DEPTH < 2) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_param
        $error("uart_rx_fifo: illegal parameter combination");
    end

    logic                 sync1_q, rxs_q;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic                 tick, tick_clr;
    rx_state_e            state_q, state_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overflow_q, overflow_d;
    logic                 push, set_frame, set_parity, set_overflow;
    logic                 fifo_full, fifo_empty;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        if (tick_clr) begin
            tick_cnt_d = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        tick_clr   = 1'b0;
        push       = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rxs_q) begin
                    state_d  = ST_START;
                    tick_clr = 1'b1;
                    os_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + OS_W'(1);
                    if (os_cnt_q == OS_HALF) begin
                        os_cnt_d = '0;
                        if (rxs_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            // Re-phase the divider so later samples land mid-bit.
                            state_d   = ST_DATA;
                            tick_clr  = 1'b1;
                            bit_cnt_d = '0;
                            par_bad_d = 1'b0;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + OS_W'(1);
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d  = '0;
                        shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + OS_W'(1);
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d  = '0;
                        par_bad_d = (PARITY == PAR_ODD) ? ~(^shift_q ^ rxs_q)
                                                        :  (^shift_q ^ rxs_q);
                        state_d   = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + OS_W'(1);
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        if (!rxs_q) begin
                            set_frame = 1'b1;
                            state_d   = ST_WAIT_IDLE;
                        end else if (par_bad_q) begin
                            set_parity = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            push    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pop on a full FIFO makes room, so only an unaccompanied push overflows.
    assign set_overflow = push && fifo_full && !rd;

    always_comb begin
        frame_err_d  = set_frame    ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
        parity_err_d = set_parity   ? 1'b1 : (clr_err ? 1'b0 : parity_err_q);
        overflow_d   = set_overflow ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            tick_cnt_q   <= '0;
            state_q      <= ST_IDLE;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= uart_rx;
            rxs_q        <= sync1_q;
            tick_cnt_q   <= tick_cnt_d;
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (shift_q),
        .pop   (rd),
        .rdata (rdata),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_valid   = !fifo_empty;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;
    assign irq        = rx_valid | frame_err_q | parity_err_q | overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_fifo: a no-parity instance and an even-parity
// instance, line rate raised so one bit is 64 clocks (divider of 4).
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int BIT_NS = 1280;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;

    logic       line0 = 1'b1, rd0 = 1'b0, clr0 = 1'b0;
    logic [7:0] rdata0;
    logic [3:0] cnt0;
    logic       rxv0, fe0, pe0, ov0, irq0;

    logic       line1 = 1'b1, rd1 = 1'b0, clr1 = 1'b0;
    logic [7:0] rdata1;
    logic [3:0] cnt1;
    logic       rxv1, fe1, pe1, ov1, irq1;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    always #10 clk = ~clk;

    uart_rx_fifo #(.CLK_FREQ(50_000_000), .BAUD(781_250), .OVERSAMPLE(16),
                   .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(8)) dut0 (
        .clk(clk), .reset(reset), .uart_rx(line0), .rd(rd0), .rdata(rdata0),
        .rx_valid(rxv0), .count(cnt0), .frame_err(fe0), .parity_err(pe0),
        .overflow(ov0), .clr_err(clr0), .irq(irq0));

    uart_rx_fifo #(.CLK_FREQ(50_000_000), .BAUD(781_250), .OVERSAMPLE(16),
                   .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .reset(reset), .uart_rx(line1), .rd(rd1), .rdata(rdata1),
        .rx_valid(rxv1), .count(cnt1), .frame_err(fe1), .parity_err(pe1),
        .overflow(ov1), .clr_err(clr1), .irq(irq1));

    task automatic send_bits(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) line0 = bits[i];
            else            line1 = bits[i];
            #(BIT_NS);
        end
    endtask

    task automatic send_frame(input int which, input logic [7:0] d);
        send_bits(which, {6'b0, 1'b1, d, 1'b0}, 10);
    endtask

    task automatic pop_entry(input int which, input string name);
        logic [7:0] e, got;
        @(negedge clk);
        e = 8'hxx;
        if (which == 0) begin
            got = rdata0;
            if (exp_q0.size() > 0) e = exp_q0.pop_front();
        end else begin
            got = rdata1;
            if (exp_q1.size() > 0) e = exp_q1.pop_front();
        end
        vectors++;
        if (got !== e) begin miscompares++; $display("FAIL %s: rdata=%h expected %h", name, got, e); end
        if (which == 0) rd0 = 1'b1; else rd1 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
        rd1 = 1'b0;
    endtask

    task automatic test_reset;
        repeat (5) @(negedge clk);
        vectors++;
        if ({rxv0, cnt0, rdata0, fe0, pe0, ov0, irq0} !== 17'd0) begin
            miscompares++; $display("FAIL reset_dut0: outputs=%h expected 0", {rxv0, cnt0, rdata0, fe0, pe0, ov0, irq0});
        end
        vectors++;
        if ({rxv1, cnt1, rdata1, fe1, pe1, ov1, irq1} !== 17'd0) begin
            miscompares++; $display("FAIL reset_dut1: outputs=%h expected 0", {rxv1, cnt1, rdata1, fe1, pe1, ov1, irq1});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_frame;
        exp_q0.push_back(8'hA5);
        send_frame(0, 8'hA5);
        @(negedge clk);
        vectors++;
        if (rxv0 !== 1'b1) begin miscompares++; $display("FAIL a5_valid: rx_valid=%b expected 1", rxv0); end
        vectors++;
        if (cnt0 !== 4'd1) begin miscompares++; $display("FAIL a5_count: count=%0d expected 1", cnt0); end
        vectors++;
        if (rdata0 !== 8'hA5) begin miscompares++; $display("FAIL a5_head: rdata=%h expected a5", rdata0); end
        vectors++;
        if (irq0 !== 1'b1) begin miscompares++; $display("FAIL a5_irq: irq=%b expected 1", irq0); end
        pop_entry(0, "a5_pop");
        vectors++;
        if (cnt0 !== 4'd0) begin miscompares++; $display("FAIL a5_count_after: count=%0d expected 0", cnt0); end
        vectors++;
        if ({rxv0, irq0} !== 2'b00) begin miscompares++; $display("FAIL a5_empty: rx_valid/irq=%b expected 00", {rxv0, irq0}); end
    endtask

    task automatic test_glitch;
        @(negedge clk);
        line0 = 1'b0;
        #200;
        line0 = 1'b1;
        #(BIT_NS);
        @(negedge clk);
        vectors++;
        if (cnt0 !== 4'd0) begin miscompares++; $display("FAIL glitch_count: count=%0d expected 0", cnt0); end
        vectors++;
        if ({fe0, pe0, ov0} !== 3'b000) begin miscompares++; $display("FAIL glitch_flags: flags=%b expected 000", {fe0, pe0, ov0}); end
        vectors++;
        if (dut0.state_q !== ST_IDLE) begin miscompares++; $display("FAIL glitch_state: state=%0d expected %0d", dut0.state_q, ST_IDLE); end
    endtask

    task automatic test_frame_err;
        send_bits(0, {7'b0, 8'h3C, 1'b0}, 9);
        line0 = 1'b0;
        #(2 * BIT_NS);
        line0 = 1'b1;
        #(BIT_NS);
        @(negedge clk);
        vectors++;
        if (fe0 !== 1'b1) begin miscompares++; $display("FAIL ferr_set: frame_err=%b expected 1", fe0); end
        vectors++;
        if (cnt0 !== 4'd0) begin miscompares++; $display("FAIL ferr_count: count=%0d expected 0", cnt0); end
        exp_q0.push_back(8'h3C);
        send_frame(0, 8'h3C);
        @(negedge clk);
        vectors++;
        if ({cnt0, fe0} !== {4'd1, 1'b1}) begin miscompares++; $display("FAIL ferr_next_frame: count/frame_err=%h expected 3", {cnt0, fe0}); end
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        vectors++;
        if (fe0 !== 1'b0) begin miscompares++; $display("FAIL ferr_clear: frame_err=%b expected 0", fe0); end
        vectors++;
        if ({irq0, rxv0, cnt0} !== {1'b1, 1'b1, 4'd1}) begin miscompares++; $display("FAIL ferr_irq_hold: irq/valid/count=%h expected 31", {irq0, rxv0, cnt0}); end
        pop_entry(0, "ferr_pop");
    endtask

    task automatic test_back_to_back;
        for (int d = 1; d <= 9; d++) begin
            if (d <= 8) exp_q0.push_back(8'(d));
            send_frame(0, 8'(d));
        end
        @(negedge clk);
        vectors++;
        if (cnt0 !== 4'd8) begin miscompares++; $display("FAIL b2b_count: count=%0d expected 8", cnt0); end
        vectors++;
        if (ov0 !== 1'b1) begin miscompares++; $display("FAIL b2b_overflow: overflow=%b expected 1", ov0); end
        for (int i = 0; i < 8; i++) pop_entry(0, "b2b_pop");
        vectors++;
        if ({rxv0, cnt0} !== 5'd0) begin miscompares++; $display("FAIL b2b_drained: valid/count=%h expected 0", {rxv0, cnt0}); end
        vectors++;
        if (rdata0 !== 8'h08) begin miscompares++; $display("FAIL b2b_hold: rdata=%h expected 08", rdata0); end
        rd0 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
        vectors++;
        if ({rdata0, cnt0} !== {8'h08, 4'd0}) begin miscompares++; $display("FAIL b2b_empty_pop: rdata/count=%h expected 080", {rdata0, cnt0}); end
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        vectors++;
        if ({ov0, irq0} !== 2'b00) begin miscompares++; $display("FAIL b2b_clr: overflow/irq=%b expected 00", {ov0, irq0}); end
    endtask

    task automatic test_parity;
        send_bits(1, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        @(negedge clk);
        vectors++;
        if (pe1 !== 1'b1) begin miscompares++; $display("FAIL par_bad: parity_err=%b expected 1", pe1); end
        vectors++;
        if (cnt1 !== 4'd0) begin miscompares++; $display("FAIL par_bad_count: count=%0d expected 0", cnt1); end
        exp_q1.push_back(8'h03);
        send_bits(1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        @(negedge clk);
        vectors++;
        if (cnt1 !== 4'd1) begin miscompares++; $display("FAIL par_good_count: count=%0d expected 1", cnt1); end
        vectors++;
        if (rdata1 !== 8'h03) begin miscompares++; $display("FAIL par_good_data: rdata=%h expected 03", rdata1); end
        pop_entry(1, "par_pop");
    endtask

    task automatic test_reset_mid;
        fork
            send_frame(0, 8'h77);
            begin
                // Land inside data bit 7 so the post-reset false start is rejected.
                #(BIT_NS * 8 + BIT_NS * 6 / 10);
                reset = 1'b1;
                #50;
                vectors++;
                if ({rxv0, cnt0, rdata0, fe0, pe0, ov0, irq0} !== 17'd0) begin
                    miscompares++; $display("FAIL rst_mid_dut0: outputs=%h expected 0", {rxv0, cnt0, rdata0, fe0, pe0, ov0, irq0});
                end
                vectors++;
                if ({rxv1, cnt1, rdata1, fe1, pe1, ov1, irq1} !== 17'd0) begin
                    miscompares++; $display("FAIL rst_mid_dut1: outputs=%h expected 0", {rxv1, cnt1, rdata1, fe1, pe1, ov1, irq1});
                end
                #50;
                reset = 1'b0;
            end
        join
        #(2 * BIT_NS);
        @(negedge clk);
        vectors++;
        if ({cnt0, fe0, pe0, ov0} !== 7'd0) begin miscompares++; $display("FAIL rst_mid_abort: count/flags=%h expected 0", {cnt0, fe0, pe0, ov0}); end
        exp_q0.push_back(8'h5A);
        send_frame(0, 8'h5A);
        @(negedge clk);
        vectors++;
        if ({cnt0, rdata0} !== {4'd1, 8'h5A}) begin miscompares++; $display("FAIL rst_mid_next: count/rdata=%h expected 15a", {cnt0, rdata0}); end
        pop_entry(0, "rst_mid_pop");
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
